// File: rtl/mul16_pkg.sv
// mul16_pkg: shared widths, FSM state type and constants for mul_16bit.
//   Q_WIDTH_DEF  quotient / remainder width
//   B_WIDTH_DEF  divisor width, also the number of shift-add steps
//   P_WIDTH_DEF  dividend width; 0xFFFF*0xFF + 0xFFFF = 0xFFFF00 fits, so no overflow
//   FIT16_MAX    largest dividend that div_16bit can take as its A input
package mul16_pkg;

  localparam int Q_WIDTH_DEF = 16;
  localparam int B_WIDTH_DEF = 8;
  localparam int P_WIDTH_DEF = Q_WIDTH_DEF + B_WIDTH_DEF;

  localparam logic [15:0] FIT16_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul16_step.sv
// mul16_step: one combinational shift-add multiply step.
//   acc, mcand, mplier           current accumulator, shifted multiplicand, multiplier
//   acc_nxt, mcand_nxt, mplier_nxt  values after one step
// The add drops any carry out; the operand ranges guarantee none occurs.
module mul16_step #(
  parameter int P_WIDTH = 24,
  parameter int B_WIDTH = 8
) (
  input  logic [P_WIDTH-1:0] acc,
  input  logic [P_WIDTH-1:0] mcand,
  input  logic [B_WIDTH-1:0] mplier,
  output logic [P_WIDTH-1:0] acc_nxt,
  output logic [P_WIDTH-1:0] mcand_nxt,
  output logic [B_WIDTH-1:0] mplier_nxt
);

  always_comb begin
    acc_nxt    = mplier[0] ? (acc + mcand) : acc;
    mcand_nxt  = mcand << 1;
    mplier_nxt = mplier >> 1;
  end

endmodule

// File: rtl/mul_16bit.sv
// mul_16bit: sequential shift-add reconstructor, dividend = quotient*divisor + remainder.
// Inverse of div_16bit; also flags whether (quotient, divisor, remainder) is a legal
// divider result.
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (quotient, divisor, remainder)
//   out_valid / out_ready result handshake (dividend, fits16, rem_ok)
//   fits16                dividend <= 0xFFFF
//   rem_ok                divisor != 0 and remainder < divisor, captured at accept
// Build option: define MUL16_EARLY_TERM_EN to leave CALC as soon as the remaining
// multiplier bits are all zero (latency = index of divisor's top set bit + 1).
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | one shift-add step per cycle
// DONE  | result presented, held until out_ready
module mul_16bit
  import mul16_pkg::*;
#(
  parameter int Q_WIDTH = Q_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF,
  parameter int P_WIDTH = Q_WIDTH + B_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [Q_WIDTH-1:0] quotient,
  input  logic [B_WIDTH-1:0] divisor,
  input  logic [Q_WIDTH-1:0] remainder,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] dividend,
  output logic               fits16,
  output logic               rem_ok
);

  localparam int CNT_W = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;

  state_t             state, state_nxt;
  logic [P_WIDTH-1:0] acc, mcand;
  logic [B_WIDTH-1:0] mplier;
  logic [CNT_W-1:0]   cnt;
  logic               rem_ok_q;

  logic [P_WIDTH-1:0] acc_step, mcand_step;
  logic [B_WIDTH-1:0] mplier_step;
  logic               last_step;

  mul16_step #(
    .P_WIDTH (P_WIDTH),
    .B_WIDTH (B_WIDTH)
  ) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .acc_nxt    (acc_step),
    .mcand_nxt  (mcand_step),
    .mplier_nxt (mplier_step)
  );

`ifdef MUL16_EARLY_TERM_EN
  // Once no multiplier bits remain, later steps cannot change acc.
  assign last_step = (cnt == CNT_W'(B_WIDTH - 1)) || (mplier_step == '0);
`else
  assign last_step = (cnt == CNT_W'(B_WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      rem_ok_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        acc      <= P_WIDTH'(remainder);
        mcand    <= P_WIDTH'(quotient);
        mplier   <= divisor;
        cnt      <= '0;
        rem_ok_q <= (divisor != '0) && (remainder < Q_WIDTH'(divisor));
      end else if (state == CALC) begin
        acc    <= acc_step;
        mcand  <= mcand_step;
        mplier <= mplier_step;
        cnt    <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready is masked by rst so it stays low through the reset cycle itself.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign dividend  = out_valid ? acc : '0;
  assign fits16    = out_valid && (acc <= P_WIDTH'(FIT16_MAX));
  assign rem_ok    = out_valid && rem_ok_q;

endmodule

// File: tb/tb_mul_16bit.sv
module tb_mul_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] quotient;
  logic [7:0]  divisor;
  logic [15:0] remainder;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] dividend;
  logic        fits16;
  logic        rem_ok;

  always #5 clk = ~clk;

  mul_16bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .quotient  (quotient),
    .divisor   (divisor),
    .remainder (remainder),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dividend  (dividend),
    .fits16    (fits16),
    .rem_ok    (rem_ok)
  );

  typedef struct {
    logic [15:0] q;
    logic [7:0]  b;
    logic [15:0] r;
    logic [23:0] d;
    logic        fits;
    logic        ok;
    int          lat_fixed;
    int          lat_early;
  } vec_t;

  typedef struct {
    logic [23:0] d;
    logic        fits;
    logic        ok;
    int          lat;
    int          acc_cyc;
  } exp_t;

  vec_t vecs [10];
  exp_t sb [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: pops the scoreboard when a result first appears, then checks
  // that it stays put while the consumer stalls.
  logic        have_res = 1'b0;
  logic [23:0] cap_d;
  logic        cap_f, cap_o;

  always @(negedge clk) begin
    if (out_valid) begin
      if (!have_res) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("dividend", 32'(dividend), 32'(e.d));
          chk("fits16",   32'(fits16),   32'(e.fits));
          chk("rem_ok",   32'(rem_ok),   32'(e.ok));
          chk("latency",  32'(cyc - e.acc_cyc), 32'(e.lat));
        end
        have_res = 1'b1;
        cap_d = dividend;
        cap_f = fits16;
        cap_o = rem_ok;
      end else begin
        chk("hold_dividend", 32'(dividend), 32'(cap_d));
        chk("hold_fits16",   32'(fits16),   32'(cap_f));
        chk("hold_rem_ok",   32'(rem_ok),   32'(cap_o));
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      if (out_ready) have_res = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(vec_t v, int hold);
    exp_t e;
    int   t;
    t = 0;
    while (!in_ready && t < 50) begin tick(); t++; end
    chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    quotient  = v.q;
    divisor   = v.b;
    remainder = v.r;
    e.d = v.d;
    e.fits = v.fits;
    e.ok = v.ok;
`ifdef MUL16_EARLY_TERM_EN
    e.lat = v.lat_early;
`else
    e.lat = v.lat_fixed;
`endif
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    tick();
    in_valid  = 1'b0;
    quotient  = 16'hDEAD;
    divisor   = 8'hA5;
    remainder = 16'hBEEF;
    t = 0;
    while (!out_valid && t < 50) begin tick(); t++; end
    chk("out_valid_timeout", 32'(out_valid), 32'd1);
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_in_ready",  32'(in_ready),  32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    //            q         b      r         d            fits  ok  fixed early
    vecs[0] = '{16'h1234, 8'h56, 16'h0012, 24'h061D8A, 1'b0, 1'b1, 8, 7};
    vecs[1] = '{16'hFFFF, 8'hFF, 16'hFFFF, 24'hFFFF00, 1'b0, 1'b0, 8, 8};
    vecs[2] = '{16'h0003, 8'h07, 16'h0002, 24'h000017, 1'b1, 1'b1, 8, 3};
    vecs[3] = '{16'h0FFF, 8'h10, 16'h000F, 24'h00FFFF, 1'b1, 1'b1, 8, 5};
    vecs[4] = '{16'h1234, 8'h00, 16'h0005, 24'h000005, 1'b1, 1'b0, 8, 1};
    vecs[5] = '{16'h0100, 8'h03, 16'h0001, 24'h000301, 1'b1, 1'b1, 8, 2};
    vecs[6] = '{16'h0200, 8'h80, 16'h007F, 24'h01007F, 1'b0, 1'b1, 8, 8};
    vecs[7] = '{16'h0000, 8'h55, 16'h0010, 24'h000010, 1'b1, 1'b1, 8, 7};
    vecs[8] = '{16'hABCD, 8'h01, 16'h0000, 24'h00ABCD, 1'b1, 1'b1, 8, 1};
    vecs[9] = '{16'h0101, 8'h02, 16'h0001, 24'h000203, 1'b1, 1'b1, 8, 2};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    quotient = '0;
    divisor = '0;
    remainder = '0;
    repeat (3) tick();
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dividend",  32'(dividend),  32'd0);
    chk("rst_fits16",    32'(fits16),    32'd0);
    chk("rst_rem_ok",    32'(rem_ok),    32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // First vector doubles as the stall test: 5 cycles with out_ready low.
    send(vecs[0], 5);
    for (int i = 1; i < 9; i++) send(vecs[i], i % 3);

    // Abort in the 4th CALC cycle; only the following operands may produce a result.
    in_valid  = 1'b1;
    quotient  = 16'h5555;
    divisor   = 8'hAA;
    remainder = 16'h0003;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("calc_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    chk("abort_in_ready",  32'(in_ready),  32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_dividend",  32'(dividend),  32'd0);
    chk("abort_fits16",    32'(fits16),    32'd0);
    chk("abort_rem_ok",    32'(rem_ok),    32'd0);
    rst = 1'b0;
    #1;
    chk("abort_release_in_ready", 32'(in_ready), 32'd1);
    send(vecs[9], 0);

    repeat (12) tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_16bit.md
Name: mul_16bit

Overview:
- Sequential shift-add reconstructor, the inverse of the team's 16-bit by 8-bit divider.
- Takes a quotient Q, divisor B and remainder R, and computes dividend = Q*B + R.
- Reports whether (Q,B,R) was a legal divider output pair.
- Sits beside div_16bit in the arithmetic datapath and is used for self-check and reconstruction; valid/ready on both sides.

Parameters:
- Q_WIDTH, 16, quotient and remainder width
- B_WIDTH, 8, divisor width; also the number of iteration steps
- P_WIDTH, Q_WIDTH+B_WIDTH (24), dividend output width; the maximum Q*B+R = 0xFFFF00 fits, so no internal overflow is possible

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- quotient  in  Q_WIDTH  Q
- divisor  in  B_WIDTH  B
- remainder  in  Q_WIDTH  R
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- dividend  out  P_WIDTH  Q*B+R
- fits16  out  1  1 when dividend <= 0xFFFF, i.e. representable as div_16bit input A
- rem_ok  out  1  1 when B != 0 and R < B

Behaviour:
- Reset: clk and rst are fixed as stated in Ports. While rst=1 at a rising edge, state=IDLE and the following outputs are 0: in_ready, out_valid, dividend, fits16, rem_ok. in_ready becomes 1 in the first cycle after reset deasserts.
- Reset mid-operation aborts the calculation with no output.
- States IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1, load the registers:
    - acc <= zero-extended R
    - mcand <= zero-extended Q (P_WIDTH bits)
    - mplier <= B
    - cnt <= 0
    - rem_ok flag <= (B != 0) && (R < B), registered at accept
  - Then go to CALC.
- CALC (in_ready=0):
  - Each edge: if mplier[0], acc <= acc + mcand (P_WIDTH-bit add, no carry out).
  - Also: mcand <= mcand << 1, mplier <= mplier >> 1, cnt <= cnt + 1.
  - When cnt == B_WIDTH-1 on that edge, go to DONE.
  - Latency is fixed: out_valid rises in the cycle after the B_WIDTH-th edge following acceptance (8 cycles by default).
- DONE:
  - out_valid=1; dividend=acc; fits16=(acc[P_WIDTH-1:16]==0); rem_ok as latched.
  - Outputs are held stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE.
  - No in/out bypass: the next accept happens earliest one cycle after the result handshake.
- Input signals other than in_valid are don't-care outside accept edges.
- B=0: dividend=R, rem_ok=0.
- Q=0: dividend=R.
- rem_ok=0 does not suppress the result.

Optional Feature:
- Macro MUL16_EARLY_TERM_EN.
- When defined: CALC also exits to DONE on any edge where the post-shift mplier becomes 0.
  - Latency = position of B's highest set bit + 1.
  - B=0 gives latency 1; B=0x80 gives latency 8.
  - Results are identical to the fixed-latency build.
- When undefined: latency is always B_WIDTH and cnt alone controls the exit.

Decomposition:
- Package mul16_pkg holds:
  - Q_WIDTH/B_WIDTH/P_WIDTH defaults
  - the state enum (IDLE, CALC, DONE)
  - the localparam FIT16_MAX=16'hFFFF
- One sub-module is natural: mul16_step, a combinational single shift-add step (acc, mcand, mplier in; next values out). The top holds the FSM, counter and registers.

Test Plan:
- Q=0x1234, B=0x56, R=0x0012 -> dividend=0x061D8A, fits16=0, rem_ok=1; out_valid exactly 8 cycles after accept (default build).
- Q=0xFFFF, B=0xFF, R=0xFFFF -> dividend=0xFFFF00, fits16=0, rem_ok=0; no wrap.
- Q=0x0003, B=0x07, R=0x0002 -> dividend=0x000017, fits16=1, rem_ok=1. Round-trip: feed div_16bit outputs for A=0x0017, B=0x07 and expect dividend=A.
- Result hold: out_ready held 0 for 5 cycles -> out_valid and dividend stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
- rst=1 asserted on the 4th CALC cycle -> next cycle IDLE with all outputs 0; a new accept afterwards gives the correct result for the new operands only.
- MUL16_EARLY_TERM_EN defined:
  - B=0x00, R=0x0005 -> dividend=0x000005 after 1 cycle.
  - B=0x03 -> latency 2.
  - B=0x80 -> latency 8.
